// File: rtl/step_input_debouncer.sv
// -----------------------------------------------------------------------------
// step_input_debouncer
//
// Purpose:
//   Conditions the manual-entry inputs of the CR16 ALU board. The mechanical
//   step push-button and the operand/opcode switch bank are synchronised to
//   I_CLK. The button is also debounced. Each accepted press produces one
//   single-cycle O_STEP pulse. The synchronised switch value is captured into
//   O_DATA on that same edge. The downstream entry sequencer advances by one
//   entry per O_STEP.
//
// Ports:
//   I_CLK         in   1             system clock, rising edge
//   I_NRESET      in   1             asynchronous active-low reset
//   I_BUTTON_N    in   1             raw step button, 0 = pressed, asynchronous
//   I_SWITCHES    in   P_DATA_WIDTH  raw switch bank, asynchronous
//   O_STEP        out  1             one-cycle pulse per accepted press
//   O_DATA        out  P_DATA_WIDTH  switch value captured with the last O_STEP
//   O_PRESSED     out  1             debounced button level, 1 = pressed
//   O_STEP_COUNT  out  16            accepted presses, wraps FFFF -> 0000
//   O_DBG_STATE   out  3             current FSM state encoding (debug only)
//
// Output protocol:
//   There is no valid/ready handshake. O_STEP is a strobe that the consumer
//   cannot stall. It is high for exactly one cycle. O_DATA is valid in that
//   cycle and holds its value until the next strobe.
// -----------------------------------------------------------------------------
module step_input_debouncer #(
    parameter int P_DATA_WIDTH      = 8,
    parameter int P_DEBOUNCE_CYCLES = 500000,
    parameter int P_SYNC_STAGES     = 2
) (
    input  logic                    I_CLK,
    input  logic                    I_NRESET,
    input  logic                    I_BUTTON_N,
    input  logic [P_DATA_WIDTH-1:0] I_SWITCHES,
    output logic                    O_STEP,
    output logic [P_DATA_WIDTH-1:0] O_DATA,
    output logic                    O_PRESSED,
    output logic [15:0]             O_STEP_COUNT,
    output logic [2:0]              O_DBG_STATE
);

    localparam int                CNT_W    = $clog2(P_DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(P_DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_ARM          = 3'd0,
        S_RELEASED     = 3'd1,
        S_PRESS_WAIT   = 3'd2,
        S_PRESSED      = 3'd3,
        S_RELEASE_WAIT = 3'd4
    } state_e;

    // Synchronisers. Index 0 is the stage fed from the pad.
    logic [P_SYNC_STAGES-1:0]                   btn_sync_q, btn_sync_d;
    logic [P_SYNC_STAGES-1:0][P_DATA_WIDTH-1:0] sw_sync_q, sw_sync_d;

    logic                    btn_s;
    logic [P_DATA_WIDTH-1:0] sw_s;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    step_q, step_d;
    logic [P_DATA_WIDTH-1:0] data_q, data_d;
    logic                    pressed_q, pressed_d;
    logic [15:0]             step_count_q, step_count_d;

    logic done;

    assign btn_s = btn_sync_q[P_SYNC_STAGES-1];
    assign sw_s  = sw_sync_q[P_SYNC_STAGES-1];

    // A counter value of P_DEBOUNCE_CYCLES-1 seen on an edge means the level
    // has been stable for P_DEBOUNCE_CYCLES edges, counting the current one.
    assign done = (cnt_q == CNT_LAST);

    always_comb begin
        btn_sync_d = {btn_sync_q[P_SYNC_STAGES-2:0], I_BUTTON_N};
        sw_sync_d  = sw_sync_q;
        sw_sync_d[0] = I_SWITCHES;
        for (int i = 1; i < P_SYNC_STAGES; i++) begin
            sw_sync_d[i] = sw_sync_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = 1'b0;
        data_d       = data_q;
        step_count_d = step_count_q;

        case (state_q)
            // Waits for a stable release first, so a button held through
            // reset cannot produce a step.
            S_ARM: begin
                if (btn_s) begin
                    if (done) begin
                        state_d = S_RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            S_RELEASED: begin
                if (!btn_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (btn_s) begin
                    // Bounce: back to released without a pulse.
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d      = S_PRESSED;
                    cnt_d        = '0;
                    step_d       = 1'b1;
                    data_d       = sw_s;
                    step_count_d = step_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_PRESSED: begin
                if (btn_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end

            S_RELEASE_WAIT: begin
                if (!btn_s) begin
                    // Release glitch: still pressed, and no second pulse.
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_ARM;
                cnt_d   = '0;
            end
        endcase

        pressed_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            btn_sync_q   <= '1;
            sw_sync_q    <= '0;
            state_q      <= S_ARM;
            cnt_q        <= '0;
            step_q       <= 1'b0;
            data_q       <= '0;
            pressed_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            btn_sync_q   <= btn_sync_d;
            sw_sync_q    <= sw_sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            data_q       <= data_d;
            pressed_q    <= pressed_d;
            step_count_q <= step_count_d;
        end
    end

    assign O_STEP       = step_q;
    assign O_DATA       = data_q;
    assign O_PRESSED    = pressed_q;
    assign O_STEP_COUNT = step_count_q;
    assign O_DBG_STATE  = state_q;

endmodule
